matrix_mac_engine: RTL
======================

# matrix_mac_engine

Sequential multiply-accumulate engine that computes C = A × B for two N×N unsigned matrices held in external synchronous-read memories. It produces the N² dot products in row-major order and emits each RW-bit result with a one-cycle `done` pulse. It sits directly upstream of the result handler, which latches `result` on each `done` and advances its own write address.

## Interface

Parameters:
- `N`, 4: matrix dimension.
- `DW`, 8: element width, unsigned.
- `RW`, 24: accumulator and result width.
- `MAW`, 4: memory address width; must be at least ceil(log2(N·N)).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; resets every register on the rising edge where it is sampled high.
- `start` in 1: level, sampled only in IDLE; begins a full matrix product.
- `a_addr` out MAW: A memory read address, computed as i·N+k.
- `b_addr` out MAW: B memory read address, computed as k·N+j.
- `a_data` in DW: A[i][k], valid one cycle after `a_addr` (synchronous read).
- `b_data` in DW: B[k][j], valid one cycle after `b_addr`.
- `result` out RW: C[i][j]; registered and held stable between `done` pulses.
- `done` out 1: one-cycle pulse; `result` is valid in the same cycle.
- `last` out 1: one-cycle pulse coincident with the `done` for C[N-1][N-1].
- `busy` out 1: high whenever the state is not IDLE.

## Operation

- Internal registers:
  - indices `i`, `j`, `k`, each in 0..N-1;
  - accumulator `acc`, RW bits;
  - state register with values IDLE, RUN and LAST.
- Reset values: state=IDLE; i=j=k=0; acc=0; result=0; done=0; last=0; busy=0; a_addr=b_addr=0.
- IDLE:
  - `start`=1 → i=j=k=0, acc=0, go to RUN.
  - Otherwise remain in IDLE.
- RUN:
  - Drive addresses for the current (i,j,k).
  - When k>0, acc += a_data·b_data, which is the product for k-1.
  - If k<N-1: k++. If k==N-1: go to LAST.
- LAST:
  - result ← acc + a_data·b_data, the product for k=N-1.
  - done ← 1 (registered); acc ← 0; k ← 0.
  - If (i,j)==(N-1,N-1): last ← 1, go to IDLE.
  - Else advance j; on j==N-1 wrap j to 0 and increment i. Go to RUN.
- Arithmetic:
  - Products are DW×DW unsigned, 2·DW bits, zero-extended to RW.
  - Accumulation wraps modulo 2^RW. No saturation and no overflow flag.
  - With the defaults, the maximum sum is 4·255² = 260100, so it cannot wrap.
- `start` while busy is ignored; it does not restart and is not queued.
- `start` held high through the final LAST → a new product begins on the edge after the return to IDLE (IDLE lasts exactly one cycle).
- `reset` mid-operation:
  - Aborts immediately; all outputs return to their reset values on that edge.
  - Any partial result is discarded and no `done` is produced.
  - `reset` has priority over `start` and over all state transitions.
- Addresses are don't-care in IDLE and LAST. In IDLE they are held at their last value, or 0 after reset.

## Timing

- Start-sample edge = E0. RUN occupies the cycles after E0..E(N-1), with k=0..N-1. LAST is the cycle after EN.
- First `done`/`result` is visible in the cycle after E(N+1).
- Each element takes N+1 cycles. Consecutive `done` pulses are exactly N+1 cycles apart, with N low cycles between them.
  - The result handler's edge-triggered capture needs these low cycles between pulses.
- Full product takes N²·(N+1) cycles; 80 cycles for N=4. The final `done`+`last` arrive in the cycle after E80.
- `busy` rises in the cycle after E0. It falls in the same cycle the final `done` rises.
- Memory contract: data for the address driven in cycle t is consumed in cycle t+1. The engine does not stall.

## Test plan

- **Identity A, B[r][c]=r·4+c:** the 16 `result` values are 0..15 in order, with `done` every 5 cycles and `last` on the 16th.
- **All-255 A and B:** every result is 260100 (0x03F804), confirming width and zero-extension.
- **Address sequence, element (1,2):** a_addr = 4,5,6,7 and b_addr = 2,6,10,14 on consecutive RUN cycles.
- **`reset` asserted at cycle 30 of a run:** the next cycle shows busy=0, result=0, done=0. A following `start` produces a correct, complete product.
- **`start` pulsed at cycles 10 and 40 during a run:** exactly 16 dones, with timing unchanged.
- **`start` held high for 200 cycles with A=B=all-1:** two back-to-back products, each result 4, with one IDLE cycle between the two `last` pulses and the next RUN.

Source files
------------

// File: rtl/matrix_mac_engine.sv
// Sequential multiply-accumulate engine: C = A x B for N x N unsigned matrices
// fetched from synchronous-read memories, one dot product every N+1 cycles.
module matrix_mac_engine #(
    parameter int N   = 4,
    parameter int DW  = 8,
    parameter int RW  = 24,
    parameter int MAW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic [MAW-1:0] a_addr,
    output logic [MAW-1:0] b_addr,
    input  logic [DW-1:0]  a_data,
    input  logic [DW-1:0]  b_data,
    output logic [RW-1:0]  result,
    output logic           done,
    output logic           last,
    output logic           busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
    localparam logic [IW-1:0]  IDX_ZERO = IW'(0);
    localparam logic [MAW-1:0] ADDR_N   = MAW'(N);
    localparam logic [MAW-1:0] ADDR_ONE = MAW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   i_r;
    logic [IW-1:0]   j_r;
    logic [IW-1:0]   k_r;
    logic [RW-1:0]   acc_r;
    logic [2*DW-1:0] prod_s;
    logic [RW-1:0]   prod_ext_s;

    // Full-width unsigned product of the memory words arriving this cycle.
    always_comb begin
        prod_s     = {{DW{1'b0}}, a_data} * {{DW{1'b0}}, b_data};
        prod_ext_s = RW'(prod_s);
    end

    // Sequencer, index counters, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            i_r     <= IDX_ZERO;
            j_r     <= IDX_ZERO;
            k_r     <= IDX_ZERO;
            acc_r   <= {RW{1'b0}};
            result  <= {RW{1'b0}};
            done    <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
            a_addr  <= {MAW{1'b0}};
            b_addr  <= {MAW{1'b0}};
        end else begin
            done <= 1'b0;
            last <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        i_r     <= IDX_ZERO;
                        j_r     <= IDX_ZERO;
                        k_r     <= IDX_ZERO;
                        acc_r   <= {RW{1'b0}};
                        a_addr  <= {MAW{1'b0}};
                        b_addr  <= {MAW{1'b0}};
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    // Data arriving now belongs to the address issued for k-1.
                    if (k_r != IDX_ZERO) begin
                        acc_r <= acc_r + prod_ext_s;
                    end else begin
                        acc_r <= acc_r;
                    end
                    if (k_r != IDX_LAST) begin
                        k_r    <= k_r + IDX_ONE;
                        a_addr <= MAW'(i_r) * ADDR_N + MAW'(k_r) + ADDR_ONE;
                        b_addr <= (MAW'(k_r) + ADDR_ONE) * ADDR_N + MAW'(j_r);
                    end else begin
                        state_r <= LAST;
                    end
                end
                LAST: begin
                    result <= acc_r + prod_ext_s;
                    done   <= 1'b1;
                    acc_r  <= {RW{1'b0}};
                    k_r    <= IDX_ZERO;
                    if ((i_r == IDX_LAST) && (j_r == IDX_LAST)) begin
                        last    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= RUN;
                        if (j_r == IDX_LAST) begin
                            j_r    <= IDX_ZERO;
                            i_r    <= i_r + IDX_ONE;
                            a_addr <= (MAW'(i_r) + ADDR_ONE) * ADDR_N;
                            b_addr <= {MAW{1'b0}};
                        end else begin
                            j_r    <= j_r + IDX_ONE;
                            a_addr <= MAW'(i_r) * ADDR_N;
                            b_addr <= MAW'(j_r) + ADDR_ONE;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
